// File: rtl/part_sram_param.sv
// part_sram_param: single-port SRAM with per-bit write mask,
// power-on zero sweep, 1 or 2 cycle read latency and busy-access error flag.
module part_sram_param #(
    parameter int AW     = 12,
    parameter int DW     = 1,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ce_n,
    input  logic          we_n,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] din,
    input  logic [DW-1:0] wmask,
    input  logic          err_clr,
    output logic [DW-1:0] dout,
    output logic          rvalid,
    output logic          busy,
    output logic          err
);

    localparam int   DEPTH = 1 << AW;
    localparam logic LAT2  = (RD_LAT == 2);

    typedef enum logic {
        S_CLEAR,
        S_IDLE
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] clr_addr_q, clr_addr_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          rvalid_q, rvalid_d;
    logic          err_q, err_d;
    logic [DW-1:0] pipe_data_q, pipe_data_d;
    logic          pipe_v_q, pipe_v_d;

    logic [DW-1:0] mem [DEPTH];
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] rd_word;
    logic          sweeping;
    logic          rd_fire;
    logic          wr_fire;

    // Controller next state, memory write port selection and read pipeline.
    always_comb begin
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        dout_d      = dout_q;
        rvalid_d    = 1'b0;
        err_d       = err_q;
        pipe_data_d = pipe_data_q;
        pipe_v_d    = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = addr;
        mem_wdata   = '0;

        sweeping = (state_q == S_CLEAR);
        rd_fire  = !ce_n && we_n && !sweeping;
        wr_fire  = !ce_n && !we_n && !sweeping;
        rd_word  = mem[addr];

        if (sweeping) begin
            mem_we     = 1'b1;
            mem_waddr  = clr_addr_q;
            mem_wdata  = '0;
            clr_addr_d = clr_addr_q + 1'b1;
            if (clr_addr_q == '1) begin
                state_d = S_IDLE;
            end
        end else if (wr_fire) begin
            mem_we    = 1'b1;
            mem_waddr = addr;
            mem_wdata = (rd_word & ~wmask) | (din & wmask);
        end

        if (LAT2) begin
            pipe_v_d = rd_fire;
            if (rd_fire) begin
                pipe_data_d = rd_word;
            end
            rvalid_d = pipe_v_q;
            if (pipe_v_q) begin
                dout_d = pipe_data_q;
            end
        end else begin
            rvalid_d = rd_fire;
            if (rd_fire) begin
                dout_d = rd_word;
            end
        end

        if (err_clr) begin
            err_d = 1'b0;
        end
        if (!ce_n && sweeping) begin
            err_d = 1'b1;
        end
    end

    // Control and read-pipeline registers; reset aborts sweep and reads.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_CLEAR;
            clr_addr_q  <= '0;
            dout_q      <= '0;
            rvalid_q    <= 1'b0;
            err_q       <= 1'b0;
            pipe_data_q <= '0;
            pipe_v_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            dout_q      <= dout_d;
            rvalid_q    <= rvalid_d;
            err_q       <= err_d;
            pipe_data_q <= pipe_data_d;
            pipe_v_q    <= pipe_v_d;
        end
    end

    // Storage array; deliberately untouched by reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign dout   = dout_q;
    assign rvalid = rvalid_q;
    assign busy   = (state_q == S_CLEAR);
    assign err    = err_q;

endmodule

// File: tb/tb_part_sram_param.sv
// tb_part_sram_param: directed bench driving a 1-cycle and a
// 2-cycle latency instance with identical stimulus.
module tb_part_sram_param;

    logic       clk;
    logic       reset_n;
    logic       ce_n;
    logic       we_n;
    logic [3:0] addr;
    logic [7:0] din;
    logic [7:0] wmask;
    logic       err_clr;
    logic [7:0] dout1, dout2;
    logic       rvalid1, rvalid2;
    logic       busy1, busy2;
    logic       err1, err2;

    int tests;
    int failed;

    part_sram_param #(.AW(4), .DW(8), .RD_LAT(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .ce_n(ce_n), .we_n(we_n),
        .addr(addr), .din(din), .wmask(wmask), .err_clr(err_clr),
        .dout(dout1), .rvalid(rvalid1), .busy(busy1), .err(err1)
    );

    part_sram_param #(.AW(4), .DW(8), .RD_LAT(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .ce_n(ce_n), .we_n(we_n),
        .addr(addr), .din(din), .wmask(wmask), .err_clr(err_clr),
        .dout(dout2), .rvalid(rvalid2), .busy(busy2), .err(err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ce_n = 1'b1;
        we_n = 1'b1;
    endtask

    task automatic rd(input logic [3:0] a);
        ce_n = 1'b0;
        we_n = 1'b1;
        addr = a;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d,
                      input logic [7:0] m);
        ce_n  = 1'b0;
        we_n  = 1'b0;
        addr  = a;
        din   = d;
        wmask = m;
    endtask

    logic [7:0] trip [3];

    initial begin
        tests   = 0;
        failed  = 0;
        reset_n = 1'b0;
        ce_n    = 1'b1;
        we_n    = 1'b1;
        addr    = '0;
        din     = '0;
        wmask   = '0;
        err_clr = 1'b0;
        trip[0] = 8'h11;
        trip[1] = 8'h22;
        trip[2] = 8'h33;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy1", {7'd0, busy1}, 8'd1);
        chk("rst_busy2", {7'd0, busy2}, 8'd1);
        chk("rst_rvalid1", {7'd0, rvalid1}, 8'd0);
        chk("rst_dout1", dout1, 8'h00);
        chk("rst_dout2", dout2, 8'h00);
        chk("rst_err1", {7'd0, err1}, 8'd0);

        reset_n = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            ce_n = (i == 5) ? 1'b0 : 1'b1;
            step();
            chk($sformatf("sweep_busy1_%0d", i), {7'd0, busy1},
                {7'd0, (i < 16)});
            chk($sformatf("sweep_busy2_%0d", i), {7'd0, busy2},
                {7'd0, (i < 16)});
            chk($sformatf("sweep_err_%0d", i), {7'd0, err1},
                {7'd0, (i >= 5)});
        end
        ce_n = 1'b1;
        chk("sweep_rvalid", {7'd0, rvalid1}, 8'd0);

        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("err_clr1", {7'd0, err1}, 8'd0);
        chk("err_clr2", {7'd0, err2}, 8'd0);

        for (int a = 0; a <= 16; a++) begin
            if (a < 16) rd(4'(a));
            else idle();
            step();
            if (a < 16) begin
                chk($sformatf("zero_rv1_%0d", a), {7'd0, rvalid1}, 8'd1);
                chk($sformatf("zero_d1_%0d", a), dout1, 8'h00);
            end
            chk($sformatf("zero_rv2_%0d", a), {7'd0, rvalid2},
                {7'd0, (a >= 1)});
            if (a >= 1) chk($sformatf("zero_d2_%0d", a), dout2, 8'h00);
        end
        step();
        chk("zero_end_rv1", {7'd0, rvalid1}, 8'd0);
        chk("zero_end_rv2", {7'd0, rvalid2}, 8'd0);

        wr(4'd3, 8'hA5, 8'hFF);
        step();
        chk("wr3_rv1", {7'd0, rvalid1}, 8'd0);
        chk("wr3_rv2", {7'd0, rvalid2}, 8'd0);
        rd(4'd3);
        step();
        chk("rd3_rv1", {7'd0, rvalid1}, 8'd1);
        chk("rd3_d1", dout1, 8'hA5);
        chk("rd3_rv2_early", {7'd0, rvalid2}, 8'd0);
        idle();
        step();
        chk("rd3_rv1_off", {7'd0, rvalid1}, 8'd0);
        chk("rd3_d1_hold", dout1, 8'hA5);
        chk("rd3_rv2", {7'd0, rvalid2}, 8'd1);
        chk("rd3_d2", dout2, 8'hA5);
        step();
        chk("rd3_rv2_off", {7'd0, rvalid2}, 8'd0);

        wr(4'd5, 8'hFF, 8'hFF);
        step();
        wr(4'd5, 8'h00, 8'h0F);
        step();
        chk("wr_hold_d1", dout1, 8'hA5);
        chk("wr_hold_d2", dout2, 8'hA5);
        rd(4'd5);
        step();
        chk("mask_rv1", {7'd0, rvalid1}, 8'd1);
        chk("mask_d1", dout1, 8'hF0);
        idle();
        step();
        chk("mask_rv2", {7'd0, rvalid2}, 8'd1);
        chk("mask_d2", dout2, 8'hF0);
        step();

        for (int k = 0; k < 3; k++) begin
            wr(4'(k), trip[k], 8'hFF);
            step();
        end
        for (int k = 0; k < 3; k++) begin
            rd(4'(k));
            step();
            chk($sformatf("b2b_rv1_%0d", k), {7'd0, rvalid1}, 8'd1);
            chk($sformatf("b2b_d1_%0d", k), dout1, trip[k]);
            if (k > 0) begin
                chk($sformatf("b2b_rv2_%0d", k), {7'd0, rvalid2}, 8'd1);
                chk($sformatf("b2b_d2_%0d", k), dout2, trip[k-1]);
            end
        end
        idle();
        step();
        chk("b2b_rv1_end", {7'd0, rvalid1}, 8'd0);
        chk("b2b_rv2_last", {7'd0, rvalid2}, 8'd1);
        chk("b2b_d2_last", dout2, 8'h33);
        step();
        chk("b2b_rv2_end", {7'd0, rvalid2}, 8'd0);

        ce_n  = 1'b1;
        we_n  = 1'b0;
        addr  = 4'd0;
        din   = 8'h00;
        wmask = 8'hFF;
        step();
        chk("noop_rv1", {7'd0, rvalid1}, 8'd0);
        rd(4'd0);
        step();
        chk("noop_d1", dout1, 8'h11);
        idle();
        step();
        chk("noop_d2", dout2, 8'h11);
        step();

        rd(4'd1);
        step();
        chk("abort_d1_pre", dout1, 8'h22);
        idle();
        reset_n = 1'b0;
        #1;
        chk("abort_rv1", {7'd0, rvalid1}, 8'd0);
        chk("abort_d1", dout1, 8'h00);
        chk("abort_rv2", {7'd0, rvalid2}, 8'd0);
        chk("abort_d2", dout2, 8'h00);
        chk("abort_busy2", {7'd0, busy2}, 8'd1);
        step();
        chk("abort_rv2_late", {7'd0, rvalid2}, 8'd0);
        chk("abort_d2_late", dout2, 8'h00);

        reset_n = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            ce_n    = (i == 3) ? 1'b0 : 1'b1;
            err_clr = (i == 3);
            step();
            chk($sformatf("resweep_busy_%0d", i), {7'd0, busy1},
                {7'd0, (i < 16)});
            chk($sformatf("resweep_err_%0d", i), {7'd0, err2},
                {7'd0, (i >= 3)});
            chk($sformatf("resweep_rv2_%0d", i), {7'd0, rvalid2}, 8'd0);
        end
        err_clr = 1'b0;

        rd(4'd0);
        step();
        chk("resweep_rv1_a0", {7'd0, rvalid1}, 8'd1);
        chk("resweep_d1_a0", dout1, 8'h00);
        rd(4'd5);
        step();
        chk("resweep_d1_a5", dout1, 8'h00);
        chk("resweep_d2_a0", dout2, 8'h00);
        idle();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("resweep_d2_a5", dout2, 8'h00);
        chk("final_err_clr", {7'd0, err1}, 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
